// File: rtl/scarv_soc_mem_pkg.sv
// Shared definitions for the SoC memory adapters.
//   ADDR_W/DATA_W/STRB_W : request/response bus field widths
//   mem_state_t          : adapter response-stage states
package scarv_soc_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/scarv_soc_rsp_hold.sv
// Response hold register: captures a response (data + error) so it survives
// back-pressure, and selects between the live and the held copy.
//   g_clk, g_resetn     : clock, asynchronous active-low reset
//   load                : capture in_rdata/in_error this cycle
//   sel                 : 1 = present held copy, 0 = pass live inputs through
//   in_rdata, in_error  : live response
//   out_rdata, out_error: selected response
module scarv_soc_rsp_hold
  import scarv_soc_mem_pkg::*;
(
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              load,
  input  logic              sel,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic              in_error,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_error
);

  logic [DATA_W-1:0] held_rdata;
  logic              held_error;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      held_rdata <= '0;
      held_error <= 1'b0;
    end else if (load) begin
      held_rdata <= in_rdata;
      held_error <= in_error;
    end
  end

  assign out_rdata = sel ? held_rdata : in_rdata;
  assign out_error = sel ? held_error : in_error;

endmodule

// File: rtl/scarv_soc_bram_bus_adapter.sv
// Valid/ready memory bus to single BRAM port adapter.
//   g_clk, g_resetn              : clock, asynchronous active-low reset
//   req_valid/ready/addr/wen/strb/wdata : request channel
//   rsp_valid/ready/rdata/error  : response channel (one outstanding request)
//   bram_en/wen/addr/wdata/rdata : BRAM port, 1-cycle read latency
// Accesses outside [BASE, BASE+DEPTH) or writes when WRITE_EN=0 complete with
// rsp_error=1 and never touch the BRAM.
module scarv_soc_bram_bus_adapter
  import scarv_soc_mem_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int unsigned DEPTH    = 1024,
  parameter bit          WRITE_EN = 1'b1,
  localparam int unsigned LW      = $clog2(DEPTH)
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [STRB_W-1:0] req_strb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              bram_en,
  output logic [STRB_W-1:0] bram_wen,
  output logic [LW-1:0]     bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  mem_state_t state, state_nxt;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              req_err;
  logic              fire;
  logic              err_q;
  logic              wr_q;
  logic              hold_load;
  logic              hold_sel;
  logic [DATA_W-1:0] live_rdata;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_error;

  // Unsigned subtraction makes addresses below BASE wrap to huge offsets,
  // so a single compare covers both window edges.
  assign offset   = req_addr - BASE;
  assign in_range = offset < DEPTH;
  assign req_err  = !in_range || (req_wen && !WRITE_EN);

  // Kept outside the FSM block so fire does not loop back through it.
  assign req_ready = (state == IDLE) || rsp_ready;
  assign fire      = req_valid && req_ready;

  assign bram_en    = fire && !req_err;
  assign bram_wen   = (bram_en && req_wen) ? req_strb : '0;
  assign bram_addr  = offset[LW-1:0];
  assign bram_wdata = req_wdata;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
      err_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        err_q <= req_err;
        wr_q  <= req_wen;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    hold_load = 1'b0;
    hold_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (fire) state_nxt = ACCESS;
      end
      ACCESS: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = fire ? ACCESS : IDLE;
        end else begin
          hold_load = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        rsp_valid = 1'b1;
        hold_sel  = 1'b1;
        if (rsp_ready) state_nxt = fire ? ACCESS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // BRAM data is only meaningful for successful reads.
  assign live_rdata = (err_q || wr_q) ? '0 : bram_rdata;

  scarv_soc_rsp_hold u_rsp_hold (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .load      (hold_load),
    .sel       (hold_sel),
    .in_rdata  (live_rdata),
    .in_error  (err_q),
    .out_rdata (sel_rdata),
    .out_error (sel_error)
  );

  assign rsp_rdata = rsp_valid ? sel_rdata : '0;
  assign rsp_error = rsp_valid && sel_error;

endmodule

// File: tb/tb_scarv_soc_bram_bus_adapter.sv
module tb_scarv_soc_bram_bus_adapter;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NW    = DEPTH / 4;

  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  // Main instance (writable, non-zero base)
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        bram_en;
  logic [3:0]  bram_wen;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata, bram_rdata;

  // ROM instance (WRITE_EN=0, base 0)
  logic        r_req_valid, r_req_ready, r_req_wen;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [3:0]  r_req_strb;
  logic        r_rsp_valid, r_rsp_ready, r_rsp_error;
  logic [31:0] r_rsp_rdata;
  logic        r_bram_en;
  logic [3:0]  r_bram_wen;
  logic [9:0]  r_bram_addr;
  logic [31:0] r_bram_wdata, r_bram_rdata;

  scarv_soc_bram_bus_adapter #(.BASE(BASE), .DEPTH(DEPTH), .WRITE_EN(1'b1)) dut (
    .g_clk(clk), .g_resetn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_strb(req_strb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .bram_en(bram_en), .bram_wen(bram_wen),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  scarv_soc_bram_bus_adapter #(.BASE(32'h0), .DEPTH(DEPTH), .WRITE_EN(1'b0)) dut_rom (
    .g_clk(clk), .g_resetn(rstn),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_addr(r_req_addr),
    .req_wen(r_req_wen), .req_strb(r_req_strb), .req_wdata(r_req_wdata),
    .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_rdata(r_rsp_rdata),
    .rsp_error(r_rsp_error), .bram_en(r_bram_en), .bram_wen(r_bram_wen),
    .bram_addr(r_bram_addr), .bram_wdata(r_bram_wdata), .bram_rdata(r_bram_rdata)
  );

  function automatic logic [31:0] init_word(int unsigned i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rom_word(int unsigned i);
    return init_word(i) ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // BRAM behavioural models: synchronous, read-first, byte write enables.
  logic [31:0] mem [NW];
  logic [31:0] rom [NW];
  logic        mem_loaded = 1'b0;
  logic [31:0] mw;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < NW; i++) begin
        mem[i] <= init_word(i);
        rom[i] <= rom_word(i);
      end
      mem_loaded <= 1'b1;
    end else begin
      if (bram_en) begin
        mw = merge(mem[bram_addr[9:2]], bram_wdata, bram_wen);
        mem[bram_addr[9:2]] <= mw;
        bram_rdata <= mem[bram_addr[9:2]];
      end
      if (r_bram_en) begin
        mw = merge(rom[r_bram_addr[9:2]], r_bram_wdata, r_bram_wen);
        rom[r_bram_addr[9:2]] <= mw;
        r_bram_rdata <= rom[r_bram_addr[9:2]];
      end
    end
  end

  // Reference view of memory contents, owned by the stimulus process.
  logic [31:0] ref_mem [NW];
  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_strb = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset.rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset.rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset.rsp_error got %b want 0", rsp_error); end
    checks++; if (bram_en !== 1'b0 || bram_wen !== 4'h0) begin errors++; $display("FAIL reset.bram got en=%b wen=%h want 0/0", bram_en, bram_wen); end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset.req_ready got %b want 1", req_ready); end
  endtask

  // One isolated transaction with rsp_ready=1: accept, then response next cycle.
  task automatic do_req(input logic [31:0] addr, input logic wen, input logic [3:0] strb,
                        input logic [31:0] wdata, input string name);
    logic [31:0] off, exp_rdata;
    logic        exp_err, exp_en;
    logic [3:0]  exp_wen;
    logic [7:0]  idx;
    off       = addr - BASE;
    exp_err   = !(off < DEPTH);
    idx       = off[9:2];
    exp_en    = !exp_err;
    exp_wen   = (exp_en && wen) ? strb : 4'h0;
    exp_rdata = (exp_err || wen) ? 32'h0 : ref_mem[idx];
    if (!exp_err && wen) ref_mem[idx] = merge(ref_mem[idx], wdata, strb);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_strb = strb; req_wdata = wdata;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s.req_ready got %b want 1", name, req_ready); end
    checks++; if (bram_en !== exp_en) begin errors++; $display("FAIL %s.bram_en got %b want %b", name, bram_en, exp_en); end
    checks++; if (bram_wen !== exp_wen) begin errors++; $display("FAIL %s.bram_wen got %h want %h", name, bram_wen, exp_wen); end
    if (exp_en) begin
      checks++; if (bram_addr !== off[9:0]) begin errors++; $display("FAIL %s.bram_addr got %h want %h", name, bram_addr, off[9:0]); end
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s.rsp_valid got %b want 1", name, rsp_valid); end
    checks++; if (rsp_rdata !== exp_rdata) begin errors++; $display("FAIL %s.rsp_rdata got %h want %h", name, rsp_rdata, exp_rdata); end
    checks++; if (rsp_error !== exp_err) begin errors++; $display("FAIL %s.rsp_error got %b want %b", name, rsp_error, exp_err); end
    checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL %s.idle_bram_en got %b want 0", name, bram_en); end
  endtask

  task automatic test_rw();
    logic [31:0] got;
    do_req(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, "wr_full");
    do_req(BASE + 32'h10, 1'b0, 4'h0, 32'h0, "rd_full");
    got = rsp_rdata;
    checks++; if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_full_const got %h want deadbeef", got); end
    do_req(BASE + 32'h10, 1'b1, 4'h1, 32'h0000_00AA, "wr_byte");
    do_req(BASE + 32'h13, 1'b0, 4'hF, 32'h0, "rd_byte");
    got = rsp_rdata;
    checks++; if (got !== 32'hDEAD_BEAA) begin errors++; $display("FAIL rd_byte_const got %h want deadbeaa", got); end
    do_req(BASE + 32'h10, 1'b1, 4'h0, $urandom, "wr_nostrb");
    do_req(BASE + 32'h10, 1'b0, 4'h0, 32'h0, "rd_nostrb");
    do_req(BASE + DEPTH, 1'b0, 4'h0, 32'h0, "rd_past_end");
    do_req(BASE - 32'd4, 1'b0, 4'h0, 32'h0, "rd_below_base");
    do_req(BASE + DEPTH, 1'b1, 4'hF, 32'h1234_5678, "wr_past_end");
    do_req(BASE + DEPTH - 32'd4, 1'b0, 4'h0, 32'h0, "rd_last_word");
    do_req(BASE, 1'b0, 4'h0, 32'h0, "rd_first_word");
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] addr, exp;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      if (i < 8) begin
        addr = BASE + ($urandom_range(0, NW - 1) << 2);
        q.push_back(ref_mem[addr[9:2]]);
        req_valid = 1'b1; req_addr = addr; req_wen = 1'b0; req_strb = 4'h0;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (i < 8) begin
        checks++; if (req_ready !== 1'b1 || bram_en !== 1'b1) begin errors++; $display("FAIL b2b[%0d].accept got ready=%b en=%b want 1/1", i, req_ready, bram_en); end
      end
      if (i > 0) begin
        exp = q.pop_front();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin errors++; $display("FAIL b2b[%0d].rsp got v=%b d=%h want 1/%h", i, rsp_valid, rsp_rdata, exp); end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] addr, exp;
    addr = BASE + ($urandom_range(0, NW - 1) << 2);
    exp  = ref_mem[addr[9:2]];
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wen = 1'b0; rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      // competing write attempt that must not be accepted
      req_valid = 1'b1; req_addr = BASE + 32'h20; req_wen = 1'b1; req_strb = 4'hF; req_wdata = $urandom;
      rsp_ready = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_error !== 1'b0) begin errors++; $display("FAIL hold[%0d].rsp got v=%b d=%h e=%b want 1/%h/0", c, rsp_valid, rsp_rdata, rsp_error, exp); end
      checks++; if (req_ready !== 1'b0 || bram_en !== 1'b0) begin errors++; $display("FAIL hold[%0d].stall got ready=%b en=%b want 0/0", c, req_ready, bram_en); end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin errors++; $display("FAIL hold.release got v=%b d=%h want 1/%h", rsp_valid, rsp_rdata, exp); end
  endtask

  task automatic test_reset_in_hold();
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'h40; req_wen = 1'b0; rsp_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    rstn = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_hold.async got v=%b d=%h want 0/0", rsp_valid, rsp_rdata); end
    repeat (2) @(negedge clk);
    rstn = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_hold.idle got ready=%b v=%b want 1/0", req_ready, rsp_valid); end
    do_req(BASE + 32'h40, 1'b0, 4'h0, 32'h0, "rd_after_rst");
  endtask

  task automatic test_rom();
    logic [31:0] exp;
    exp = rom_word(0);
    @(negedge clk);
    r_req_valid = 1'b1; r_req_addr = 32'h0; r_req_wen = 1'b1; r_req_strb = 4'hF; r_req_wdata = 32'hCAFE_F00D;
    r_rsp_ready = 1'b1;
    #1;
    checks++; if (r_req_ready !== 1'b1 || r_bram_en !== 1'b0) begin errors++; $display("FAIL rom_wr.accept got ready=%b en=%b want 1/0", r_req_ready, r_bram_en); end
    @(negedge clk);
    r_req_wen = 1'b0; r_req_strb = 4'h0;
    #1;
    checks++; if (r_rsp_valid !== 1'b1 || r_rsp_error !== 1'b1 || r_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rom_wr.rsp got v=%b e=%b d=%h want 1/1/0", r_rsp_valid, r_rsp_error, r_rsp_rdata); end
    checks++; if (r_bram_en !== 1'b1) begin errors++; $display("FAIL rom_rd.bram_en got %b want 1", r_bram_en); end
    @(negedge clk);
    r_req_valid = 1'b0;
    #1;
    checks++; if (r_rsp_valid !== 1'b1 || r_rsp_error !== 1'b0 || r_rsp_rdata !== exp) begin errors++; $display("FAIL rom_rd.rsp got v=%b e=%b d=%h want 1/0/%h", r_rsp_valid, r_rsp_error, r_rsp_rdata, exp); end
  endtask

  // Random traffic against a one-deep pending-response model.
  task automatic test_random();
    logic        pend, p_err, exp_ready, exp_fire, exp_en, e;
    logic [31:0] p_data, addr, off;
    pend = 1'b0; p_err = 1'b0; p_data = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        addr = BASE + ($urandom_range(0, NW - 1) << 2) + $urandom_range(0, 3);
      end else begin
        case ($urandom_range(0, 2))
          0:       addr = BASE + DEPTH + ($urandom_range(0, 255) << 2);
          1:       addr = BASE - ($urandom_range(1, 64) << 2);
          default: addr = $urandom;
        endcase
      end
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = addr;
      req_wen   = $urandom_range(0, 1);
      req_strb  = $urandom_range(0, 15);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      off       = addr - BASE;
      e         = !(off < DEPTH);
      exp_ready = !pend || rsp_ready;
      exp_fire  = req_valid && exp_ready;
      exp_en    = exp_fire && !e;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd[%0d].req_ready got %b want %b", c, req_ready, exp_ready); end
      checks++; if (bram_en !== exp_en) begin errors++; $display("FAIL rnd[%0d].bram_en got %b want %b", c, bram_en, exp_en); end
      checks++; if (rsp_valid !== pend) begin errors++; $display("FAIL rnd[%0d].rsp_valid got %b want %b", c, rsp_valid, pend); end
      if (pend) begin
        checks++; if (rsp_rdata !== p_data || rsp_error !== p_err) begin errors++; $display("FAIL rnd[%0d].rsp got d=%h e=%b want %h/%b", c, rsp_rdata, rsp_error, p_data, p_err); end
      end
      if (pend && rsp_ready) pend = 1'b0;
      if (exp_fire) begin
        pend   = 1'b1;
        p_err  = e;
        p_data = (e || req_wen) ? 32'h0 : ref_mem[off[9:2]];
        if (!e && req_wen) ref_mem[off[9:2]] = merge(ref_mem[off[9:2]], req_wdata, req_strb);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    r_req_valid = 1'b0; r_req_addr = '0; r_req_wen = 1'b0; r_req_strb = '0;
    r_req_wdata = '0; r_rsp_ready = 1'b1;
    test_reset();
    test_rom();
    test_rw();
    test_back_to_back();
    test_hold();
    test_reset_in_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
